// File: rtl/hazard_ctrl.sv
// RAW hazard / multi-cycle sequencing for the 3-stage pipeline; stall, bubble and fwd_* are same-cycle combinational.
// Backpressure: stall holds PC and IF/ID; ex_hold freezes ID/EX while the multi-cycle op occupies EX.
module hazard_ctrl #(
    parameter bit          FORWARD    = 1'b1,
    parameter logic [2:0]  MUL_OP     = 3'b111,
    parameter int          MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_wb,
    input  logic [4:0]  id_rd,
    input  logic [2:0]  id_alu_sig,
    output logic        stall,
    output logic        bubble,
    output logic        ex_hold,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        busy,
    output logic [15:0] stall_count
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit         MULTI    = (MUL_CYCLES > 1);
    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        ex_wb, wb_wb;
    logic [4:0]  ex_rd, wb_rd;
    logic [15:0] stall_cnt_q;

    logic match_ex_a, match_wb_a, match_ex_b, match_wb_b;
    logic in_busy, hazard, issue, start_mul;

    always_comb begin
        match_ex_a = id_valid & id_use_rs & ex_wb & (ex_rd == id_rs) & (id_rs != 5'd0);
        match_wb_a = id_valid & id_use_rs & wb_wb & (wb_rd == id_rs) & (id_rs != 5'd0);
        match_ex_b = id_valid & id_use_rt & ex_wb & (ex_rd == id_rt) & (id_rt != 5'd0);
        match_wb_b = id_valid & id_use_rt & wb_wb & (wb_rd == id_rt) & (id_rt != 5'd0);
        in_busy    = (state == BUSY);
        hazard     = FORWARD ? 1'b0 : (match_ex_a | match_wb_a | match_ex_b | match_wb_b);
    end

    // Reset forces every output low, regardless of registered state.
    always_comb begin
        stall   = ~rst & (hazard | in_busy);
        ex_hold = ~rst & in_busy;
        busy    = ~rst & in_busy;
        bubble  = stall & ~ex_hold;
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        if (FORWARD && !rst) begin
            if (match_ex_a)      fwd_a = 2'b01;
            else if (match_wb_a) fwd_a = 2'b10;
            if (match_ex_b)      fwd_b = 2'b01;
            else if (match_wb_b) fwd_b = 2'b10;
        end
    end

    assign issue       = id_valid & ~stall;
    assign start_mul   = issue & (id_alu_sig == MUL_OP) & MULTI;
    assign stall_count = rst ? 16'd0 : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            ex_wb       <= 1'b0;
            ex_rd       <= 5'd0;
            wb_wb       <= 1'b0;
            wb_rd       <= 5'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mul) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // While EX is held the producer stays put and WB sees a nop.
            if (in_busy) begin
                wb_wb <= 1'b0;
            end else begin
                wb_wb <= ex_wb;
                wb_rd <= ex_rd;
                ex_wb <= issue & id_wb;
                ex_rd <= id_rd;
            end

            if (stall && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, randomized run against an occupancy model, counter saturation.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       wb;
        logic [4:0] rd;
        logic [2:0] alu;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic        ex_hold;
        logic        busy;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic [15:0] sc;
    } out_t;

    typedef struct {
        bit   which;
        in_t  in;
        out_t exp;
    } vec_t;

    // Model: the instruction occupying EX with its remaining EX cycles, plus the one in WB.
    typedef struct {
        bit         ex_v;
        logic [4:0] ex_rd;
        int         ex_left;
        bit         wb_v;
        logic [4:0] wb_rd;
        int         sc;
        int         raw;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t  in0, in1, in15;
    out_t o0, o1, o15;
    int   n_chk = 0;
    int   n_fail = 0;

    logic st0, bu0, ho0, by0, st1, bu1, ho1, by1, st15, bu15, ho15, by15;
    logic [1:0] fa0, fb0, fa1, fb1, fa15, fb15;
    logic [15:0] sc0, sc1, sc15;

    hazard_ctrl #(.FORWARD(1'b0), .MUL_OP(3'b111), .MUL_CYCLES(3)) dut0 (
        .clk(clk), .rst(in0.rst), .id_valid(in0.valid), .id_rs(in0.rs), .id_rt(in0.rt),
        .id_use_rs(in0.use_rs), .id_use_rt(in0.use_rt), .id_wb(in0.wb), .id_rd(in0.rd),
        .id_alu_sig(in0.alu), .stall(st0), .bubble(bu0), .ex_hold(ho0), .fwd_a(fa0),
        .fwd_b(fb0), .busy(by0), .stall_count(sc0));

    hazard_ctrl #(.FORWARD(1'b1), .MUL_OP(3'b111), .MUL_CYCLES(3)) dut1 (
        .clk(clk), .rst(in1.rst), .id_valid(in1.valid), .id_rs(in1.rs), .id_rt(in1.rt),
        .id_use_rs(in1.use_rs), .id_use_rt(in1.use_rt), .id_wb(in1.wb), .id_rd(in1.rd),
        .id_alu_sig(in1.alu), .stall(st1), .bubble(bu1), .ex_hold(ho1), .fwd_a(fa1),
        .fwd_b(fb1), .busy(by1), .stall_count(sc1));

    hazard_ctrl #(.FORWARD(1'b0), .MUL_OP(3'b111), .MUL_CYCLES(15)) dut15 (
        .clk(clk), .rst(in15.rst), .id_valid(in15.valid), .id_rs(in15.rs), .id_rt(in15.rt),
        .id_use_rs(in15.use_rs), .id_use_rt(in15.use_rt), .id_wb(in15.wb), .id_rd(in15.rd),
        .id_alu_sig(in15.alu), .stall(st15), .bubble(bu15), .ex_hold(ho15), .fwd_a(fa15),
        .fwd_b(fb15), .busy(by15), .stall_count(sc15));

    assign o0  = {st0, bu0, ho0, by0, fa0, fb0, sc0};
    assign o1  = {st1, bu1, ho1, by1, fa1, fb1, sc1};
    assign o15 = {st15, bu15, ho15, by15, fa15, fb15, sc15};

    function automatic in_t mk_in(bit r, bit v, int rs, int rt, bit urs, bit urt, bit wb, int rd, int alu);
        in_t i;
        i.rst = r; i.valid = v; i.rs = 5'(rs); i.rt = 5'(rt);
        i.use_rs = urs; i.use_rt = urt; i.wb = wb; i.rd = 5'(rd); i.alu = 3'(alu);
        return i;
    endfunction

    function automatic out_t mk_out(bit s, bit b, bit h, bit y, int fa, int fb, int sc);
        out_t o;
        o.stall = s; o.bubble = b; o.ex_hold = h; o.busy = y;
        o.fwd_a = 2'(fa); o.fwd_b = 2'(fb); o.sc = 16'(sc);
        return o;
    endfunction

    function automatic mdl_t m_reset();
        mdl_t m;
        m.ex_v = 0; m.ex_rd = 0; m.ex_left = 0; m.wb_v = 0; m.wb_rd = 0; m.sc = 0; m.raw = 0;
        return m;
    endfunction

    function automatic out_t m_out(mdl_t m, in_t i, bit fwd);
        out_t o;
        bit ea, wa, eb, wb, by, hz;
        o = '0;
        if (i.rst) return o;
        ea = i.valid && i.use_rs && m.ex_v && i.rs == m.ex_rd && i.rs != 0;
        wa = i.valid && i.use_rs && m.wb_v && i.rs == m.wb_rd && i.rs != 0;
        eb = i.valid && i.use_rt && m.ex_v && i.rt == m.ex_rd && i.rt != 0;
        wb = i.valid && i.use_rt && m.wb_v && i.rt == m.wb_rd && i.rt != 0;
        by = m.ex_left > 1;
        hz = !fwd && (ea || wa || eb || wb);
        o.stall = hz || by;
        o.busy = by;
        o.ex_hold = by;
        o.bubble = o.stall && !by;
        if (fwd) begin
            o.fwd_a = ea ? 2'd1 : (wa ? 2'd2 : 2'd0);
            o.fwd_b = eb ? 2'd1 : (wb ? 2'd2 : 2'd0);
        end
        o.sc = 16'(m.sc);
        return o;
    endfunction

    function automatic mdl_t m_step(mdl_t m, in_t i, bit fwd, int mc);
        mdl_t n;
        out_t o;
        bit iss;
        if (i.rst) return m_reset();
        n = m;
        o = m_out(m, i, fwd);
        if (o.stall) begin
            n.raw = m.raw + 1;
            n.sc = (m.sc < 65535) ? m.sc + 1 : 65535;
        end
        if (o.busy) begin
            n.ex_left = m.ex_left - 1;
            n.wb_v = 0;
        end else begin
            iss = i.valid && !o.stall;
            n.wb_v = m.ex_v;
            n.wb_rd = m.ex_rd;
            n.ex_v = iss && i.wb;
            n.ex_rd = i.rd;
            n.ex_left = (iss && i.alu == 3'b111) ? mc : 1;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input out_t act, input out_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got stall=%b bubble=%b hold=%b busy=%b fa=%b fb=%b sc=%h, required stall=%b bubble=%b hold=%b busy=%b fa=%b fb=%b sc=%h",
                     nm, act.stall, act.bubble, act.ex_hold, act.busy, act.fwd_a, act.fwd_b, act.sc,
                     exp.stall, exp.bubble, exp.ex_hold, exp.busy, exp.fwd_a, exp.fwd_b, exp.sc);
        end
    endtask

    vec_t vecs[$];
    mdl_t m0, m1, m15;
    in_t  idle, ri, cons, mul;
    int   cyc;

    initial begin
        idle = '0;
        // FORWARD=1, MUL_CYCLES=3: forwarding, priority, register 0, multi-cycle, reset in BUSY
        vecs.push_back('{1'b1, mk_in(0,1,1,2,1,1,1,5,0),  mk_out(0,0,0,0,0,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,5,3,1,1,1,6,0),  mk_out(0,0,0,0,1,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,4,5,1,1,0,8,0),  mk_out(0,0,0,0,0,2,0)});
        vecs.push_back('{1'b1, mk_in(0,1,0,0,1,1,1,0,0),  mk_out(0,0,0,0,0,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,0,0,1,1,0,0,0),  mk_out(0,0,0,0,0,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,0,0,1,1,0,0,0),  mk_out(0,0,0,0,0,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,1,1,1,1,1,9,0),  mk_out(0,0,0,0,0,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,2,2,1,1,1,9,0),  mk_out(0,0,0,0,0,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,9,9,1,0,0,0,0),  mk_out(0,0,0,0,1,0,0)});
        vecs.push_back('{1'b1, mk_in(0,0,9,9,1,1,1,9,0),  mk_out(0,0,0,0,0,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,9,9,1,1,0,0,0),  mk_out(0,0,0,0,0,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,1,2,1,1,1,7,7),  mk_out(0,0,0,0,0,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,7,0,1,0,1,10,0), mk_out(1,0,1,1,1,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,7,0,1,0,1,10,0), mk_out(1,0,1,1,1,0,1)});
        vecs.push_back('{1'b1, mk_in(0,1,7,0,1,0,1,10,0), mk_out(0,0,0,0,1,0,2)});
        vecs.push_back('{1'b1, mk_in(0,1,7,10,1,1,0,0,0), mk_out(0,0,0,0,2,1,2)});
        vecs.push_back('{1'b1, mk_in(0,1,0,0,1,1,1,11,7), mk_out(0,0,0,0,0,0,2)});
        vecs.push_back('{1'b1, mk_in(0,1,0,0,1,1,1,12,7), mk_out(1,0,1,1,0,0,2)});
        vecs.push_back('{1'b1, mk_in(0,1,0,0,1,1,1,12,7), mk_out(1,0,1,1,0,0,3)});
        vecs.push_back('{1'b1, mk_in(0,1,0,0,1,1,1,12,7), mk_out(0,0,0,0,0,0,4)});
        vecs.push_back('{1'b1, mk_in(0,0,0,0,0,0,0,0,0),  mk_out(1,0,1,1,0,0,4)});
        vecs.push_back('{1'b1, mk_in(0,0,0,0,0,0,0,0,0),  mk_out(1,0,1,1,0,0,5)});
        vecs.push_back('{1'b1, mk_in(0,0,0,0,0,0,0,0,0),  mk_out(0,0,0,0,0,0,6)});
        vecs.push_back('{1'b1, mk_in(0,1,0,0,1,1,1,7,7),  mk_out(0,0,0,0,0,0,6)});
        vecs.push_back('{1'b1, mk_in(1,1,7,0,1,0,0,0,0),  mk_out(0,0,0,0,0,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,7,0,1,0,0,0,0),  mk_out(0,0,0,0,0,0,0)});
        vecs.push_back('{1'b1, mk_in(0,1,7,0,1,0,0,0,0),  mk_out(0,0,0,0,0,0,0)});
        // FORWARD=0, MUL_CYCLES=3: two-cycle RAW stall, BUSY overriding a hazard, register 0
        vecs.push_back('{1'b0, mk_in(0,1,1,2,1,1,1,5,0),  mk_out(0,0,0,0,0,0,0)});
        vecs.push_back('{1'b0, mk_in(0,1,5,3,1,1,1,6,0),  mk_out(1,1,0,0,0,0,0)});
        vecs.push_back('{1'b0, mk_in(0,1,5,3,1,1,1,6,0),  mk_out(1,1,0,0,0,0,1)});
        vecs.push_back('{1'b0, mk_in(0,1,5,3,1,1,1,6,0),  mk_out(0,0,0,0,0,0,2)});
        vecs.push_back('{1'b0, mk_in(0,1,4,5,1,1,0,0,0),  mk_out(0,0,0,0,0,0,2)});
        vecs.push_back('{1'b0, mk_in(0,1,1,2,1,1,1,7,7),  mk_out(0,0,0,0,0,0,2)});
        vecs.push_back('{1'b0, mk_in(0,1,7,0,1,0,1,10,0), mk_out(1,0,1,1,0,0,2)});
        vecs.push_back('{1'b0, mk_in(0,1,7,0,1,0,1,10,0), mk_out(1,0,1,1,0,0,3)});
        vecs.push_back('{1'b0, mk_in(0,1,7,0,1,0,1,10,0), mk_out(1,1,0,0,0,0,4)});
        vecs.push_back('{1'b0, mk_in(0,1,7,0,1,0,1,10,0), mk_out(1,1,0,0,0,0,5)});
        vecs.push_back('{1'b0, mk_in(0,1,7,0,1,0,1,10,0), mk_out(0,0,0,0,0,0,6)});
        vecs.push_back('{1'b0, mk_in(0,1,0,0,1,1,1,0,0),  mk_out(0,0,0,0,0,0,6)});
        vecs.push_back('{1'b0, mk_in(0,1,0,0,1,1,0,0,0),  mk_out(0,0,0,0,0,0,6)});

        // Reset: outputs must be low while rst is high
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in0 = mk_in(1,1,3,3,1,1,1,3,7); in1 = in0; in15 = in0;
            #1;
            chk($sformatf("reset0_%0d", k), o0, '0);
            chk($sformatf("reset1_%0d", k), o1, '0);
            chk($sformatf("reset15_%0d", k), o15, '0);
        end

        foreach (vecs[k]) begin
            @(negedge clk);
            in0 = vecs[k].which ? idle : vecs[k].in;
            in1 = vecs[k].which ? vecs[k].in : idle;
            in15 = idle;
            #1;
            chk($sformatf("vec%0d", k), vecs[k].which ? o1 : o0, vecs[k].exp);
        end

        // Randomized run, all three configurations against the model
        @(negedge clk);
        in0 = mk_in(1,0,0,0,0,0,0,0,0); in1 = in0; in15 = in0;
        m0 = m_reset(); m1 = m_reset(); m15 = m_reset();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            ri.rst    = ($urandom_range(0, 49) == 0);
            ri.valid  = ($urandom_range(0, 4) != 0);
            ri.rs     = 5'($urandom_range(0, 3));
            ri.rt     = 5'($urandom_range(0, 3));
            ri.use_rs = 1'($urandom);
            ri.use_rt = 1'($urandom);
            ri.wb     = ($urandom_range(0, 3) != 0);
            ri.rd     = 5'($urandom_range(0, 3));
            ri.alu    = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom);
            in0 = ri; in1 = ri; in15 = ri;
            #1;
            chk($sformatf("rnd0_%0d", k), o0, m_out(m0, ri, 1'b0));
            chk($sformatf("rnd1_%0d", k), o1, m_out(m1, ri, 1'b1));
            chk($sformatf("rnd15_%0d", k), o15, m_out(m15, ri, 1'b0));
            m0 = m_step(m0, ri, 1'b0, 3);
            m1 = m_step(m1, ri, 1'b1, 3);
            m15 = m_step(m15, ri, 1'b0, 15);
        end

        // Saturation: dependent 15-cycle ops with stalling keep stall high ~16 of 17 cycles
        @(negedge clk);
        in0 = idle; in1 = idle; in15 = mk_in(1,0,0,0,0,0,0,0,0);
        m15 = m_reset();
        mul = mk_in(0,1,5,0,1,0,1,5,7);
        cyc = 0;
        while (m15.raw < 65540 && cyc < 75000) begin
            @(negedge clk);
            in15 = mul;
            #1;
            if (m15.sc == 65534 || m15.sc == 65535 && m15.raw == 65535 || cyc % 4096 == 0)
                chk($sformatf("sat_%0d", cyc), o15, m_out(m15, mul, 1'b0));
            m15 = m_step(m15, mul, 1'b0, 15);
            cyc++;
        end
        if (m15.raw < 65540) begin
            n_chk++;
            n_fail++;
            $display("FAIL sat_budget: stall cycles reached %0d, required at least 65540", m15.raw);
        end
        @(negedge clk);
        cons = mk_in(0,0,0,0,0,0,0,0,0);
        in15 = cons;
        #1;
        n_chk++;
        if (sc15 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_final: stall_count=%h required ffff", sc15);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
